// File: rtl/svutest_pkg.sv
// svutest_pkg
// Shared types for the utest test-control handshake.
//   responder_state_e  : phase of the DUT-side test responder
//   responder_result_t : verdict bundle the regression list reads after done
package svutest_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    RUN,
    DRAIN,
    REPORT
  } responder_state_e;

  // Counter width of the result record seen by the list; responders built
  // with a narrower CNT_W are zero-extended into it.
  localparam int unsigned RESULT_CNT_W = 16;

  typedef struct packed {
    logic                    pass;
    logic                    timed_out;
    logic [RESULT_CNT_W-1:0] check_count;
    logic [RESULT_CNT_W-1:0] err_count;
  } responder_result_t;

endpackage

// File: rtl/svutest_sat_counter.sv
// svutest_sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset, clears count
//   clr   : synchronous clear (wins over inc)
//   inc   : add one this cycle unless already saturated
//   count : current value
module svutest_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/svutest_test_responder.sv
// svutest_test_responder
// DUT-side end of the test-control handshake. A start from the list walks
// the DUT through RESET -> RUN -> DRAIN -> REPORT while checker results are
// tallied; REPORT holds done and the verdict until the next start or rst.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : one-cycle request to begin a test (IDLE/REPORT only)
//   busy          : high in RESET/RUN/DRAIN
//   done, pass    : REPORT indication and verdict (pass valid with done)
//   dut_rst       : reset to DUT and stimulus (IDLE/RESET)
//   stim_en       : stimulus enable (RUN only)
//   stim_done     : stimulus finished
//   check_valid   : one checker comparison this cycle
//   check_pass    : result of that comparison
//   check_count   : saturating number of checks counted
//   err_count     : saturating number of failed checks
//   timed_out     : watchdog fired
//
// Build option SVUTEST_TEST_RESPONDER_WATCHDOG_EN: when defined, a RUN
// that lasts TIMEOUT_CYCLES cycles without stim_done ends straight in REPORT
// with timed_out=1. When undefined, RUN waits forever and timed_out is 0.
module svutest_test_responder
  import svutest_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned DRAIN_CYCLES   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             dut_rst,
  output logic             stim_en,
  input  logic             stim_done,
  input  logic             check_valid,
  input  logic             check_pass,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] err_count,
  output logic             timed_out
);

  if (RST_CYCLES < 1 || DRAIN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("svutest_test_responder: cycle parameters must be >= 1");
  end

  // One down-counter times both RESET and DRAIN; it never serves both at once.
  localparam int unsigned PH_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] RST_LOAD   = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0] DRAIN_LOAD = PH_W'(DRAIN_CYCLES - 1);

  responder_state_e state;
  logic [PH_W-1:0]  phase_cnt;
  logic             accept;
  logic             counting;

  assign accept   = ((state == IDLE) || (state == REPORT)) && start;
  assign counting = (state == RUN) || (state == DRAIN);

`ifdef SVUTEST_TEST_RESPONDER_WATCHDOG_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;
  logic            tmo;

  // wd_cnt is zero on every RUN entry because it is held clear outside RUN.
  assign wd_hit = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || (state != RUN))
      wd_cnt <= '0;
    else if (!wd_hit)
      wd_cnt <= wd_cnt + 1'b1;
  end

  assign timed_out = tmo;
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase_cnt <= '0;
`ifdef SVUTEST_TEST_RESPONDER_WATCHDOG_EN
      tmo       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, REPORT: begin
          if (start) begin
            state     <= RESET;
            phase_cnt <= RST_LOAD;
`ifdef SVUTEST_TEST_RESPONDER_WATCHDOG_EN
            tmo       <= 1'b0;
`endif
          end
        end
        RESET: begin
          if (phase_cnt == '0) state <= RUN;
          else                 phase_cnt <= phase_cnt - 1'b1;
        end
        RUN: begin
          // stim_done has priority over a watchdog expiring in the same cycle.
          if (stim_done) begin
            state     <= DRAIN;
            phase_cnt <= DRAIN_LOAD;
          end
`ifdef SVUTEST_TEST_RESPONDER_WATCHDOG_EN
          else if (wd_hit) begin
            state <= REPORT;
            tmo   <= 1'b1;
          end
`endif
        end
        DRAIN: begin
          if (phase_cnt == '0) state <= REPORT;
          else                 phase_cnt <= phase_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  svutest_sat_counter #(.W(CNT_W)) u_check_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (counting && check_valid),
    .count (check_count)
  );

  svutest_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (counting && check_valid && !check_pass),
    .count (err_count)
  );

  // Outputs decode from the registered state; REPORT releases dut_rst so the
  // DUT's final state stays visible.
  assign busy    = (state == RESET) || (state == RUN) || (state == DRAIN);
  assign done    = (state == REPORT);
  assign dut_rst = (state == IDLE) || (state == RESET);
  assign stim_en = (state == RUN);
  assign pass    = done && (err_count == '0) && (check_count != '0) && !timed_out;

endmodule

// File: tb/tb_svutest_test_responder.sv
module tb_svutest_test_responder;
  localparam int R  = 4;
  localparam int D  = 8;
  localparam int TO = 50;
  localparam int P_IDLE = 0, P_RESET = 1, P_RUN = 2, P_DRAIN = 3, P_REPORT = 4;

  logic clk = 1'b0;
  logic rst, start, stim_done, check_valid, check_pass;
  logic busy, done, pass, dut_rst, stim_en, timed_out;
  logic [15:0] check_count, err_count;
  logic n_busy, n_done, n_pass, n_dut_rst, n_stim_en, n_timed_out;
  logic [1:0] n_check_count, n_err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  svutest_test_responder #(.RST_CYCLES(R), .DRAIN_CYCLES(D), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .dut_rst(dut_rst), .stim_en(stim_en), .stim_done(stim_done),
    .check_valid(check_valid), .check_pass(check_pass),
    .check_count(check_count), .err_count(err_count), .timed_out(timed_out)
  );

  // Narrow-counter copy on the same inputs, to exercise saturation cheaply.
  svutest_test_responder #(.RST_CYCLES(R), .DRAIN_CYCLES(D), .TIMEOUT_CYCLES(TO), .CNT_W(2)) dut_n (
    .clk(clk), .rst(rst), .start(start), .busy(n_busy), .done(n_done), .pass(n_pass),
    .dut_rst(n_dut_rst), .stim_en(n_stim_en), .stim_done(stim_done),
    .check_valid(check_valid), .check_pass(check_pass),
    .check_count(n_check_count), .err_count(n_err_count), .timed_out(n_timed_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: a test is described by the time t since it started and
  // the time sd_t at which stim_done was seen; the phase follows from those.
  bit m_valid = 0, m_started = 0, m_to = 0;
  int t = 0, sd_t = -1;
  int m_cnt = 0, m_err = 0, n_cnt = 0, n_err = 0;

  function automatic int phase_of();
    if (!m_started)     return P_IDLE;
    if (m_to)           return P_REPORT;
    if (t < R)          return P_RESET;
    if (sd_t < 0)       return P_RUN;
    if (t <= sd_t + D)  return P_DRAIN;
    return P_REPORT;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  always @(posedge clk) begin : model
    int ph;
    ph = phase_of();
    if (rst) begin
      m_valid <= 1; m_started <= 0; m_to <= 0;
      m_cnt <= 0; m_err <= 0; n_cnt <= 0; n_err <= 0;
    end else if ((ph == P_IDLE || ph == P_REPORT) && start) begin
      m_started <= 1; t <= 0; sd_t <= -1; m_to <= 0;
      m_cnt <= 0; m_err <= 0; n_cnt <= 0; n_err <= 0;
    end else begin
      if ((ph == P_RUN || ph == P_DRAIN) && check_valid) begin
        m_cnt <= sat(m_cnt, 65535);
        n_cnt <= sat(n_cnt, 3);
        if (!check_pass) begin
          m_err <= sat(m_err, 65535);
          n_err <= sat(n_err, 3);
        end
      end
      if (ph == P_RUN && stim_done) sd_t <= t;
`ifdef SVUTEST_TEST_RESPONDER_WATCHDOG_EN
      if (ph == P_RUN && !stim_done && (t - R + 1) == TO) m_to <= 1;
`endif
      t <= t + 1;
    end
  end

  always @(negedge clk) begin : compare
    int ph;
    if (m_valid) begin
      ph = phase_of();
      chk("busy", busy, (ph == P_RESET || ph == P_RUN || ph == P_DRAIN));
      chk("done", done, (ph == P_REPORT));
      chk("dut_rst", dut_rst, (ph == P_IDLE || ph == P_RESET));
      chk("stim_en", stim_en, (ph == P_RUN));
      chk("timed_out", timed_out, m_to);
      chk("check_count", check_count, m_cnt);
      chk("err_count", err_count, m_err);
      chk("pass", pass, (ph == P_REPORT && m_err == 0 && m_cnt != 0 && !m_to));
      chk("n_busy", n_busy, (ph == P_RESET || ph == P_RUN || ph == P_DRAIN));
      chk("n_done", n_done, (ph == P_REPORT));
      chk("n_dut_rst", n_dut_rst, (ph == P_IDLE || ph == P_RESET));
      chk("n_stim_en", n_stim_en, (ph == P_RUN));
      chk("n_timed_out", n_timed_out, m_to);
      chk("n_check_count", n_check_count, n_cnt);
      chk("n_err_count", n_err_count, n_err);
      chk("n_pass", n_pass, (ph == P_REPORT && n_err == 0 && n_cnt != 0 && !m_to));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stim_done = 0; check_valid = 0; check_pass = 0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (stim_en !== 1'b1 && n < 50) begin tick(); n++; end
    chk("wait_run", stim_en, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 200) begin tick(); n++; end
    chk("wait_done", done, 1);
  endtask

  task automatic start_test();
    start = 1; tick(); start = 0;
  endtask

  initial begin
    int n;
    idle_inputs();
    rst = 1; tick(); tick();
    chk("rst_dut_rst", dut_rst, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_pass", pass, 0); chk("rst_stim_en", stim_en, 0);
    chk("rst_cnt", check_count, 0); chk("rst_timed_out", timed_out, 0);
    rst = 0; tick();

    // Start latency: RST_CYCLES cycles of dut_rst, then stimulus.
    start_test();
    chk("rs_busy", busy, 1); chk("rs_dut_rst", dut_rst, 1); chk("rs_stim_en", stim_en, 0);
    repeat (R - 1) tick();
    chk("rs_last_dut_rst", dut_rst, 1); chk("rs_last_stim_en", stim_en, 0);
    tick();
    chk("run_stim_en", stim_en, 1); chk("run_dut_rst", dut_rst, 0);

    // 5 passing checks in RUN, 2 in DRAIN, drain length.
    check_valid = 1; check_pass = 1;
    repeat (5) tick();
    check_valid = 0; stim_done = 1; tick(); stim_done = 0;
    chk("drain_stim_en", stim_en, 0); chk("drain_busy", busy, 1);
    check_valid = 1; check_pass = 1; tick(); tick(); check_valid = 0;
    n = 2;
    while (done !== 1'b1 && n < 40) begin tick(); n++; end
    chk("drain_len", n, D);
    chk("a_cnt", check_count, 7); chk("a_err", err_count, 0); chk("a_pass", pass, 1);
    chk("a_busy", busy, 0); chk("a_dut_rst", dut_rst, 0);

    // Restart from REPORT; start during RUN ignored; 10 checks with 3 fails,
    // the last arriving together with stim_done.
    start_test();
    chk("rep_start_done", done, 0); chk("rep_start_busy", busy, 1);
    chk("rep_start_cnt", check_count, 0);
    wait_run();
    start_test();
    chk("run_start_ign_stim_en", stim_en, 1); chk("run_start_ign_dut_rst", dut_rst, 0);
    for (int i = 0; i < 10; i++) begin
      check_valid = 1;
      check_pass = !(i == 1 || i == 4 || i == 7);
      stim_done = (i == 9);
      tick();
    end
    idle_inputs();
    wait_done();
    chk("b_cnt", check_count, 10); chk("b_err", err_count, 3); chk("b_pass", pass, 0);
    chk("b_n_cnt", n_check_count, 3);

    // 6 failures: narrow counter saturates at 3.
    start_test(); wait_run();
    check_valid = 1; check_pass = 0;
    repeat (6) tick();
    idle_inputs(); stim_done = 1; tick(); stim_done = 0;
    wait_done();
    chk("c_err", err_count, 6); chk("c_n_err", n_err_count, 3); chk("c_n_cnt", n_check_count, 3);

    // No checks at all fails.
    start_test(); wait_run();
    repeat (19) tick();
    stim_done = 1; tick(); stim_done = 0;
    wait_done();
    chk("d_cnt", check_count, 0); chk("d_pass", pass, 0);

    // rst in the middle of DRAIN aborts with no report.
    start_test(); wait_run();
    stim_done = 1; tick(); stim_done = 0;
    repeat (3) tick();
    rst = 1; tick(); rst = 0;
    chk("e_busy", busy, 0); chk("e_done", done, 0); chk("e_dut_rst", dut_rst, 1);
    repeat (12) tick();
    chk("e_done_later", done, 0);

    // Endless RUN: watchdog or indefinite wait.
    start_test(); wait_run();
    check_valid = 1; check_pass = 1;
`ifdef SVUTEST_TEST_RESPONDER_WATCHDOG_EN
    n = 1;
    while (stim_en === 1'b1 && n < 200) begin tick(); n++; end
    idle_inputs();
    chk("wd_run_len", n, TO);
    chk("wd_timed_out", timed_out, 1); chk("wd_done", done, 1); chk("wd_pass", pass, 0);
`else
    repeat (1000) tick();
    chk("nowd_busy", busy, 1); chk("nowd_stim_en", stim_en, 1);
    idle_inputs(); stim_done = 1; tick(); stim_done = 0;
    wait_done();
    chk("nowd_pass", pass, 1);
`endif

    // Random traffic against the model.
    idle_inputs();
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom % 400) == 0;
      start       = ($urandom % 6) == 0;
      stim_done   = ($urandom % 30) == 0;
      check_valid = ($urandom % 2) == 0;
      check_pass  = ($urandom % 5) != 0;
      tick();
    end
    idle_inputs(); rst = 0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
